// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM with byte enables, fixed response latency,
// one outstanding load/store, addr_ok/data_ok handshake toward the MEM stage.
module dmem_responder #(
  parameter int          AW        = 10,
  parameter int          LATENCY   = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req,
  input  logic        wr,
  input  logic [3:0]  be,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int         DEPTH    = 1 << AW;
  localparam logic [32:0] SPAN    = 33'(1) << (AW + 2);
  localparam logic [3:0] LAT_LAST = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q;
  logic [3:0]  be_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        err_q;
  logic        ld_ok_q;

  logic        accept;
  logic        enter_resp;
  logic        ram_en;
  logic        cur_wr;
  logic [3:0]  cur_be;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic [31:0] off;
  logic        addr_err;
  logic [AW-1:0] idx;
  logic [31:0] rd_word;

  assign addr_ok = (state_q == IDLE);
  assign data_ok = (state_q == RESP);
  assign accept  = req && addr_ok;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          cnt_d   = '0;
          state_d = (LATENCY == 1) ? RESP : BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_d == LAT_LAST) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // With LATENCY==1 the RAM access happens on the accept edge itself, so the
  // live inputs stand in for the not-yet-captured request.
  assign cur_wr    = (state_q == IDLE) ? wr    : wr_q;
  assign cur_be    = (state_q == IDLE) ? be    : be_q;
  assign cur_addr  = (state_q == IDLE) ? addr  : addr_q;
  assign cur_wdata = (state_q == IDLE) ? wdata : wdata_q;

  assign off        = cur_addr - BASE_ADDR;
  assign addr_err   = (cur_addr[1:0] != 2'b00) || ({1'b0, off} >= SPAN);
  assign idx        = off[AW+1:2];
  assign enter_resp = (state_d == RESP);
  assign ram_en     = enter_resp && rstn;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      ld_ok_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        wr_q    <= wr;
        be_q    <= be;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
      if (enter_resp) begin
        err_q   <= addr_err;
        ld_ok_q <= !cur_wr && !addr_err;
      end
    end
  end

  // One byte-wide RAM lane per enable; registered read keeps each lane block-RAM shaped.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] mem_b [DEPTH];
    logic [7:0] rd_q;

    always_ff @(posedge clk) begin
      if (ram_en) begin
        if (cur_wr && !addr_err && cur_be[gi]) mem_b[idx] <= cur_wdata[8*gi +: 8];
        rd_q <= mem_b[idx];
      end
    end

    assign rd_word[8*gi +: 8] = rd_q;
  end

  assign rdata = ld_ok_q ? rd_word : 32'h0;
  assign err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed plus randomized checks of dmem_responder against a word-level memory model,
// with a LATENCY=2 instance for most tests and a LATENCY=1 instance for back-to-back timing.
module tb_dmem_responder;

  localparam int          LAT  = 2;
  localparam int          AW   = 10;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req, wr;
  logic [3:0]  be;
  logic [31:0] addr, wdata;
  logic        addr_ok, data_ok, err;
  logic [31:0] rdata;

  logic        r1_req, r1_wr;
  logic [3:0]  r1_be;
  logic [31:0] r1_addr, r1_wdata;
  logic        r1_addr_ok, r1_data_ok, r1_err;
  logic [31:0] r1_rdata;

  int total = 0;
  int bad   = 0;
  logic [31:0] model [int unsigned];

  always #5 clk = ~clk;

  dmem_responder #(.AW(AW), .LATENCY(LAT), .BASE_ADDR(BASE)) u_dut (
    .clk(clk), .rstn(rstn), .req(req), .wr(wr), .be(be), .addr(addr), .wdata(wdata),
    .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata), .err(err)
  );

  dmem_responder #(.AW(AW), .LATENCY(1), .BASE_ADDR(BASE)) u_dut1 (
    .clk(clk), .rstn(rstn), .req(r1_req), .wr(r1_wr), .be(r1_be), .addr(r1_addr),
    .wdata(r1_wdata), .addr_ok(r1_addr_ok), .data_ok(r1_data_ok), .rdata(r1_rdata),
    .err(r1_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic is_err(input logic [31:0] a);
    logic [31:0] o;
    o = a - BASE;
    return (a % 4 != 0) || (o >= 32'(4 * (1 << AW)));
  endfunction

  function automatic int unsigned key(input logic [31:0] a);
    return (a - BASE) / 4;
  endfunction

  // One full transaction on the LATENCY=2 instance; starts and ends at a negedge in IDLE.
  task automatic txn(input string tag, input logic w, input logic [3:0] b,
                     input logic [31:0] a, input logic [31:0] d);
    int n;
    logic e;
    logic [31:0] exp_rd, cur;
    e      = is_err(a);
    exp_rd = 32'h0;
    if (!e && !w) exp_rd = model[key(a)];
    req = 1'b1; wr = w; be = b; addr = a; wdata = d;
    chk({tag, ".addr_ok"}, 32'(addr_ok), 32'd1);
    @(posedge clk); #1;
    req = 1'b0; wr = 1'($urandom); be = 4'($urandom); addr = $urandom; wdata = $urandom;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!data_ok && n < 20);
    chk({tag, ".latency"}, 32'(n), 32'(LAT));
    chk({tag, ".err"}, 32'(err), 32'(e));
    chk({tag, ".rdata"}, rdata, exp_rd);
    if (!e && w) begin
      cur = model.exists(key(a)) ? model[key(a)] : 32'h0;
      for (int i = 0; i < 4; i++) if (b[i]) cur[8*i +: 8] = d[8*i +: 8];
      model[key(a)] = cur;
    end
    @(negedge clk);
    chk({tag, ".pulse_end"}, 32'(data_ok), 32'd0);
    $display("txn %s wr=%0d be=%b addr=%h wdata=%h -> err=%0d rdata=%h lat=%0d",
             tag, w, b, a, d, err, rdata, n);
  endtask

  initial begin
    int n;
    rstn = 1'b0;
    req = 1'b0; wr = 1'b0; be = 4'h0; addr = 32'h0; wdata = 32'h0;
    r1_req = 1'b0; r1_wr = 1'b0; r1_be = 4'h0; r1_addr = 32'h0; r1_wdata = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst.addr_ok", 32'(addr_ok), 32'd1);
    chk("rst.data_ok", 32'(data_ok), 32'd0);
    chk("rst.rdata", rdata, 32'h0);
    chk("rst.err", 32'(err), 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    txn("st10", 1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF);
    txn("ld10", 1'b0, 4'h0, 32'h10, 32'h0);
    chk("ld10.const", model[key(32'h10)], 32'hDEAD_BEEF);
    txn("st10_b0", 1'b1, 4'b0001, 32'h10, 32'h0000_0055);
    txn("ld10_b0", 1'b0, 4'h0, 32'h10, 32'h0);
    txn("st10_hi", 1'b1, 4'b1100, 32'h10, 32'h1122_0000);
    txn("ld10_hi", 1'b0, 4'h0, 32'h10, 32'h0);
    txn("st10_be0", 1'b1, 4'b0000, 32'h10, 32'hFFFF_FFFF);
    txn("ld10_be0", 1'b0, 4'h0, 32'h10, 32'h0);

    txn("ld_mis", 1'b0, 4'h0, 32'h13, 32'h0);
    txn("st_oor", 1'b1, 4'hF, BASE + 32'(4 * (1 << AW)), 32'hFFFF_FFFF);
    txn("st_wrap", 1'b1, 4'hF, 32'hFFFF_FFFC, 32'hFFFF_FFFF);
    txn("ld10_after_err", 1'b0, 4'h0, 32'h10, 32'h0);

    // req held high: accept every LAT+1 cycles, addr_ok low in BUSY/RESP
    req = 1'b1; wr = 1'b0; be = 4'h0; addr = 32'h10; wdata = 32'h0;
    for (int i = 0; i < 3 * (LAT + 1); i++) begin
      chk($sformatf("hold.addr_ok%0d", i), 32'(addr_ok), 32'(i % (LAT + 1) == 0));
      chk($sformatf("hold.data_ok%0d", i), 32'(data_ok), 32'(i % (LAT + 1) == LAT));
      if (data_ok) chk($sformatf("hold.rdata%0d", i), rdata, model[key(32'h10)]);
      @(negedge clk);
    end
    req = 1'b0;
    $display("txn hold: three back-to-back loads @00000010 done");

    // single-cycle req during BUSY is dropped
    req = 1'b1; wr = 1'b0; addr = 32'h10;
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    req = 1'b1; wr = 1'b1; be = 4'hF; addr = 32'h10; wdata = 32'h0;
    @(negedge clk);
    req = 1'b0;
    chk("drop.data_ok", 32'(data_ok), 32'd1);
    chk("drop.rdata", rdata, model[key(32'h10)]);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("drop.idle%0d", i), 32'(data_ok), 32'd0);
    end
    $display("txn drop: pulse during BUSY ignored");
    txn("ld10_after_drop", 1'b0, 4'h0, 32'h10, 32'h0);

    // async reset during RESP of a load
    req = 1'b1; wr = 1'b0; addr = 32'h10;
    @(posedge clk); #1;
    req = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!data_ok && n < 20);
    chk("rstresp.rdata_before", rdata, model[key(32'h10)]);
    rstn = 1'b0;
    #1;
    chk("rstresp.addr_ok", 32'(addr_ok), 32'd1);
    chk("rstresp.data_ok", 32'(data_ok), 32'd0);
    chk("rstresp.rdata", rdata, 32'h0);
    chk("rstresp.err", 32'(err), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    $display("txn reset during RESP");

    // async reset during BUSY of a store abandons it
    txn("st20", 1'b1, 4'hF, 32'h20, 32'h0BAD_F00D);
    req = 1'b1; wr = 1'b1; be = 4'hF; addr = 32'h20; wdata = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("rstbusy.data_ok", 32'(data_ok), 32'd0);
    chk("rstbusy.addr_ok", 32'(addr_ok), 32'd1);
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("rstbusy.no_resp%0d", i), 32'(data_ok), 32'd0);
    end
    $display("txn reset during BUSY");
    txn("ld20_after_rst", 1'b0, 4'h0, 32'h20, 32'h0);

    // randomized traffic over a small prefilled window plus error addresses
    for (int i = 0; i < 8; i++) txn("fill", 1'b1, 4'hF, 32'h100 + 32'(4 * i), $urandom);
    for (int i = 0; i < 40; i++) begin
      int kind;
      logic [31:0] a;
      kind = $urandom_range(0, 9);
      a = 32'h100 + 32'(4 * $urandom_range(0, 7));
      if (kind == 0) a = a + 32'($urandom_range(1, 3));
      else if (kind == 1) a = BASE + 32'(4 * (1 << AW)) + 32'(4 * $urandom_range(0, 255));
      else if (kind == 2) a = 32'hFFFF_FFF0;
      txn("rnd", 1'($urandom), 4'($urandom), a, $urandom);
    end

    // LATENCY=1 instance: store, then held loads accepted every second cycle
    r1_req = 1'b1; r1_wr = 1'b1; r1_be = 4'hF; r1_addr = 32'h40; r1_wdata = 32'h1234_5678;
    chk("l1.addr_ok0", 32'(r1_addr_ok), 32'd1);
    @(posedge clk); #1;
    r1_wr = 1'b0; r1_wdata = 32'h0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      chk($sformatf("l1.addr_ok%0d", i), 32'(r1_addr_ok), 32'(i % 2 == 0));
      chk($sformatf("l1.data_ok%0d", i), 32'(r1_data_ok), 32'(i % 2 == 1));
      if (i >= 3 && i % 2 == 1) begin
        chk($sformatf("l1.rdata%0d", i), r1_rdata, 32'h1234_5678);
        chk($sformatf("l1.err%0d", i), 32'(r1_err), 32'd0);
      end
    end
    r1_req = 1'b0;
    $display("txn latency1: store then back-to-back loads @00000040");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
